// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl
// Hazard and forwarding control for the 5-stage MIPS pipeline.
// The block shadows destination-register information for the instructions
// in EX and MEM. It produces registered select lines for the two cascaded
// operand muxes on each ALU input, and a combinational one-cycle
// load-use stall. There is no 32-bit datapath in this block.
//
// Only EX and MEM are kept as slots. The WB stage is tracked implicitly:
// an instruction's forward selects already record whether the value it
// needs will be in WB while it sits in EX. WB->ID hazards are resolved by
// the write-first register file, so no WB slot state is ever consulted.
module hazard_fwd_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  input  logic             freeze,
  output logic             stall,
  output logic             ex_fwd_a_wb,
  output logic             ex_fwd_a_mem,
  output logic             ex_fwd_b_wb,
  output logic             ex_fwd_b_mem,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // A slot produces register r when it is live, writes the register file
  // and targets r. Register $0 is hard-wired and never produced.
  function automatic logic slot_writes(
    input logic             valid,
    input logic             regwrite,
    input logic [REG_W-1:0] dst,
    input logic [REG_W-1:0] r
  );
    slot_writes = valid && regwrite && (dst == r) && (r != REG_ZERO);
  endfunction

  // EX slot
  logic             ex_valid_r;
  logic [REG_W-1:0] ex_dst_r;
  logic             ex_regwrite_r;
  logic             ex_memread_r;

  // MEM slot (memread is no longer relevant once the load has left EX)
  logic             mem_valid_r;
  logic [REG_W-1:0] mem_dst_r;
  logic             mem_regwrite_r;

  // Forward select registers and stall counter
  logic             fwd_a_wb_r;
  logic             fwd_a_mem_r;
  logic             fwd_b_wb_r;
  logic             fwd_b_mem_r;
  logic [CNT_W-1:0] stall_cnt_r;

  // Combinational decisions
  logic             ex_load_s;
  logic             rs_load_dep_s;
  logic             rt_load_dep_s;
  logic             stall_s;
  logic             accept_s;
  logic             nxt_a_wb_s;
  logic             nxt_a_mem_s;
  logic             nxt_b_wb_s;
  logic             nxt_b_mem_s;

  // Load-use detection, ID acceptance and next forward selects
  always_comb begin
    ex_load_s     = 1'b0;
    rs_load_dep_s = 1'b0;
    rt_load_dep_s = 1'b0;
    stall_s       = 1'b0;
    accept_s      = 1'b0;
    nxt_a_wb_s    = 1'b0;
    nxt_a_mem_s   = 1'b0;
    nxt_b_wb_s    = 1'b0;
    nxt_b_mem_s   = 1'b0;

    // A load in EX whose data is not available until the end of MEM
    ex_load_s = ex_valid_r && ex_memread_r && ex_regwrite_r && (ex_dst_r != REG_ZERO);

    rs_load_dep_s = id_uses_rs && (id_rs == ex_dst_r);
    rt_load_dep_s = id_uses_rt && (id_rt == ex_dst_r);

    // A flushed ID instruction is discarded anyway, so it never stalls
    if (id_valid && !flush && ex_load_s && (rs_load_dep_s || rt_load_dep_s)) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end

    accept_s = id_valid && !stall_s && !flush;

    if (accept_s) begin
      // EX producer becomes MEM next cycle; a load there cannot forward yet
      nxt_a_mem_s = id_uses_rs && !ex_memread_r &&
                    slot_writes(ex_valid_r, ex_regwrite_r, ex_dst_r, id_rs);
      nxt_b_mem_s = id_uses_rt && !ex_memread_r &&
                    slot_writes(ex_valid_r, ex_regwrite_r, ex_dst_r, id_rt);
      // MEM producer becomes WB next cycle
      nxt_a_wb_s  = id_uses_rs &&
                    slot_writes(mem_valid_r, mem_regwrite_r, mem_dst_r, id_rs);
      nxt_b_wb_s  = id_uses_rt &&
                    slot_writes(mem_valid_r, mem_regwrite_r, mem_dst_r, id_rt);
    end else begin
      // Bubble entering EX carries no forwarding
      nxt_a_wb_s  = 1'b0;
      nxt_a_mem_s = 1'b0;
      nxt_b_wb_s  = 1'b0;
      nxt_b_mem_s = 1'b0;
    end
  end

  // Pipeline slot shadow: advance on every unfrozen edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_r     <= 1'b0;
      ex_dst_r       <= REG_ZERO;
      ex_regwrite_r  <= 1'b0;
      ex_memread_r   <= 1'b0;
      mem_valid_r    <= 1'b0;
      mem_dst_r      <= REG_ZERO;
      mem_regwrite_r <= 1'b0;
    end else if (!freeze) begin
      mem_valid_r    <= ex_valid_r;
      mem_dst_r      <= ex_dst_r;
      mem_regwrite_r <= ex_regwrite_r;
      if (accept_s) begin
        ex_valid_r    <= 1'b1;
        ex_dst_r      <= id_dst;
        ex_regwrite_r <= id_regwrite;
        ex_memread_r  <= id_memread;
      end else begin
        ex_valid_r    <= 1'b0;
        ex_dst_r      <= REG_ZERO;
        ex_regwrite_r <= 1'b0;
        ex_memread_r  <= 1'b0;
      end
    end
  end

  // Forward select registers: valid for the whole EX cycle of the instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_a_wb_r  <= 1'b0;
      fwd_a_mem_r <= 1'b0;
      fwd_b_wb_r  <= 1'b0;
      fwd_b_mem_r <= 1'b0;
    end else if (!freeze) begin
      fwd_a_wb_r  <= nxt_a_wb_s;
      fwd_a_mem_r <= nxt_a_mem_s;
      fwd_b_wb_r  <= nxt_b_wb_s;
      fwd_b_mem_r <= nxt_b_mem_s;
    end
  end

  // Saturating count of effective load-use stall cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (!freeze && stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end
  end

  assign stall        = stall_s;
  assign ex_fwd_a_wb  = fwd_a_wb_r;
  assign ex_fwd_a_mem = fwd_a_mem_r;
  assign ex_fwd_b_wb  = fwd_b_wb_r;
  assign ex_fwd_b_mem = fwd_b_mem_r;
  assign stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl
// Scoreboard bench: the driver applies one ID-stage instruction per cycle,
// advances an instruction-level pipeline model and queues the expected
// outputs; a monitor on the falling edge pops and compares.
module tb_hazard_fwd_ctrl;

  localparam int RW   = 5;
  localparam int CW   = 4;              // small counter so saturation is reachable
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic          rstn;
    logic          v;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic          urs;
    logic          urt;
    logic [RW-1:0] dst;
    logic          rw;
    logic          mr;
    logic          fl;
    logic          fz;
  } in_t;

  // An instruction in flight, with the forward selects it received on entering EX
  typedef struct {
    logic          v;
    logic [RW-1:0] dst;
    logic          rw;
    logic          mr;
    logic [3:0]    fwd;  // {a_wb, a_mem, b_wb, b_mem}
  } instr_t;

  typedef struct {
    logic       stall;
    logic [3:0] fwd;
    int         cnt;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_uses_rs;
  logic          id_uses_rt;
  logic [RW-1:0] id_dst;
  logic          id_regwrite;
  logic          id_memread;
  logic          flush;
  logic          freeze;
  logic          stall;
  logic          ex_fwd_a_wb;
  logic          ex_fwd_a_mem;
  logic          ex_fwd_b_wb;
  logic          ex_fwd_b_mem;
  logic [CW-1:0] stall_cnt;

  hazard_fwd_ctrl #(.REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .freeze(freeze), .stall(stall), .ex_fwd_a_wb(ex_fwd_a_wb),
    .ex_fwd_a_mem(ex_fwd_a_mem), .ex_fwd_b_wb(ex_fwd_b_wb),
    .ex_fwd_b_mem(ex_fwd_b_mem), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     tests = 0;
  int     fails = 0;
  exp_t   sb[$];
  instr_t pipe[0:2];  // 0 = EX, 1 = MEM, 2 = WB
  int     cnt_m;
  in_t    prev;
  in_t    cur;
  logic   last_stall;

  function automatic logic produces(input instr_t s, input logic [RW-1:0] r);
    return s.v && s.rw && (s.dst == r) && (r != 5'd0);
  endfunction

  // Load-use: ID reads the register a load in EX is about to fetch
  function automatic logic m_stall(input in_t p);
    logic dep;
    dep = (p.urs && p.rs == pipe[0].dst) || (p.urt && p.rt == pipe[0].dst);
    return p.v && !p.fl && pipe[0].v && pipe[0].mr && pipe[0].rw &&
           (pipe[0].dst != 5'd0) && dep;
  endfunction

  // Effect of one clock edge with inputs p on the instruction-level model
  task automatic m_edge(input in_t p);
    instr_t nr;
    logic   st;
    if (!p.rstn) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 5'd0, 1'b0, 1'b0, 4'd0};
      cnt_m = 0;
    end else if (!p.fz) begin
      st = m_stall(p);
      nr = '{1'b0, 5'd0, 1'b0, 1'b0, 4'd0};
      if (p.v && !st && !p.fl) begin
        nr.v   = 1'b1;
        nr.dst = p.dst;
        nr.rw  = p.rw;
        nr.mr  = p.mr;
        // The instruction now in EX will be in MEM, the one in MEM in WB
        nr.fwd = {p.urs && produces(pipe[1], p.rs),
                  p.urs && produces(pipe[0], p.rs) && !pipe[0].mr,
                  p.urt && produces(pipe[1], p.rt),
                  p.urt && produces(pipe[0], p.rt) && !pipe[0].mr};
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nr;
      if (st && cnt_m < CMAX) cnt_m = cnt_m + 1;
    end
  endtask

  // One cycle: commit last edge to the model, drive new inputs, queue expectation
  task automatic drv(input in_t c);
    exp_t e;
    @(posedge clk);
    #2;
    m_edge(prev);
    rst_n       = c.rstn;
    id_valid    = c.v;
    id_rs       = c.rs;
    id_rt       = c.rt;
    id_uses_rs  = c.urs;
    id_uses_rt  = c.urt;
    id_dst      = c.dst;
    id_regwrite = c.rw;
    id_memread  = c.mr;
    flush       = c.fl;
    freeze      = c.fz;
    prev        = c;
    e.stall     = m_stall(c);
    e.fwd       = pipe[0].fwd;
    e.cnt       = cnt_m;
    last_stall  = e.stall;
    sb.push_back(e);
  endtask

  function automatic in_t mk(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                             input logic urs, input logic urt,
                             input logic [RW-1:0] dst, input logic rw,
                             input logic mr, input logic fl, input logic fz);
    in_t t;
    t = '{1'b1, 1'b1, rs, rt, urs, urt, dst, rw, mr, fl, fz};
    return t;
  endfunction

  // Present an instruction until ID accepts it (stalls repeat it)
  task automatic issue(input in_t c);
    int guard;
    drv(c);
    guard = 0;
    while (last_stall && guard < 4) begin
      drv(c);
      guard++;
    end
  endtask

  task automatic idle(input int n);
    in_t t;
    t = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < n; i++) drv(t);
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (stall !== e.stall) begin
        fails++;
        $display("FAIL stall t=%0t got %b exp %b", $time, stall, e.stall);
      end
      tests++;
      if ({ex_fwd_a_wb, ex_fwd_a_mem, ex_fwd_b_wb, ex_fwd_b_mem} !== e.fwd) begin
        fails++;
        $display("FAIL fwd t=%0t got %b exp %b", $time,
                 {ex_fwd_a_wb, ex_fwd_a_mem, ex_fwd_b_wb, ex_fwd_b_mem}, e.fwd);
      end
      tests++;
      if (stall_cnt !== CW'(e.cnt)) begin
        fails++;
        $display("FAIL stall_cnt t=%0t got %0d exp %0d", $time, stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    in_t t;
    prev = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    rst_n = 1'b0; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_dst = 5'd0; id_regwrite = 1'b0;
    id_memread = 1'b0; flush = 1'b0; freeze = 1'b0;
    cnt_m = 0;
    last_stall = 1'b0;
    drv(prev);               // reset edge
    idle(2);                 // reset-state checks

    // add r3,r1,r2 ; sub r4,r3,r5
    issue(mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(mk(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(3);
    // add r3 ; unrelated ; or r6,r7,r3
    issue(mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(mk(5'd8, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(mk(5'd7, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(3);
    // add r3 ; addi r3 ; sub r4,r3,r3
    issue(mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(mk(5'd3, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(mk(5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(3);
    // lw r2,0(r1) ; add r5,r2,r2
    issue(mk(5'd1, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0));
    issue(mk(5'd2, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(3);
    // lw r0 ; user of r0
    issue(mk(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    issue(mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(3);
    // load-use pair with flush in the hazard cycle
    issue(mk(5'd1, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0));
    drv(mk(5'd2, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0));
    idle(3);
    // load-use under a 3-cycle freeze
    issue(mk(5'd1, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) drv(mk(5'd2, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1));
    issue(mk(5'd2, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(2);

    // Randomised traffic over a small register set to provoke hazards
    for (int n = 0; n < 2000; n++) begin
      if (!(last_stall || prev.fz) || !prev.rstn || $urandom_range(0, 9) == 0) begin
        t.v   = ($urandom_range(0, 99) < 85);
        t.rs  = RW'($urandom_range(0, 3));
        t.rt  = RW'($urandom_range(0, 3));
        t.urs = ($urandom_range(0, 99) < 80);
        t.urt = ($urandom_range(0, 99) < 60);
        t.dst = RW'($urandom_range(0, 3));
        t.rw  = ($urandom_range(0, 99) < 80);
        t.mr  = ($urandom_range(0, 99) < 35);
        t.fl  = ($urandom_range(0, 99) < 8);
      end else begin
        t = prev;
      end
      t.fz   = ($urandom_range(0, 99) < 10);
      t.rstn = !(n == 1000 || n == 1600);
      drv(t);
    end
    idle(2);

    @(negedge clk);
    @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
